// File: rtl/chi_stage_pkg.sv
// Shared definitions for the chi round stage.
// Holds the slice geometry, the counter width, the FSM state encoding and the
// lane-index macro IDX(x, y) shared with the other round stages.
// Build option: define CHI_PIPELINE_EN for the overlapped read/write FSM.
`ifndef IDX
`define IDX(x, y) (5 * (y) + (x))
`endif

package chi_stage_pkg;

   localparam int unsigned SLICE_W    = 25;
   localparam int unsigned NUM_SLICES = 64;
   localparam int unsigned CNT_W      = 6;

   localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

`ifdef CHI_PIPELINE_EN
   typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;
`else
   typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;
`endif

endpackage

// File: rtl/chi_stage_if.sv
// Handshake and slice-memory bus of the chi stage.
// start/busy/done: request handshake.
// rd_en/rd_addr/rd_data: source slice memory, data one cycle after rd_en.
// wr_en/wr_addr/wr_data: destination slice memory consumed by the iota stage.
// Modport master is the chi stage itself; slave is its environment.
interface chi_stage_if
   import chi_stage_pkg::*;
();

   logic               start;
   logic               busy;
   logic               done;
   logic               rd_en;
   logic [CNT_W-1:0]   rd_addr;
   logic [SLICE_W-1:0] rd_data;
   logic               wr_en;
   logic [CNT_W-1:0]   wr_addr;
   logic [SLICE_W-1:0] wr_data;

   modport master (
      input  start, rd_data,
      output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
   );

   modport slave (
      output start, rd_data,
      input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/chi_stage_row.sv
// Chi applied to one 5-bit row (the chi_row function of the stage).
// row_in: 5 lanes x = 0..4 of one row; row_out: chi result.
module chi_stage_row (
   input  logic [4:0] row_in,
   output logic [4:0] row_out
);

   always_comb begin
      row_out = '0;
      for (int x = 0; x < 5; x++) begin
         row_out[x] = row_in[x] ^ (~row_in[(x + 1) % 5] & row_in[(x + 2) % 5]);
      end
   end

endmodule

// File: rtl/chi_stage.sv
// Chi stage: walks the 64 slices of the state, applies chi to every row and
// writes the result slice to the memory read by the iota stage.
// Ports: clk, rst (synchronous, active low), bus (chi_stage_if.master).
// Build option CHI_PIPELINE_EN: reads and writes overlap (one slice per cycle);
// otherwise each slice takes a read cycle followed by a write cycle.
module chi_stage
   import chi_stage_pkg::*;
(
   input logic         clk,
   input logic         rst,
   chi_stage_if.master bus
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   rd_addr_q, rd_addr_d;
   logic [CNT_W-1:0]   wr_addr_q, wr_addr_d;
   logic [SLICE_W-1:0] chi_out;
   logic               wr_en;

   for (genvar y = 0; y < 5; y++) begin : g_row
      chi_stage_row u_row (
         .row_in  (bus.rd_data[`IDX(0, y) +: 5]),
         .row_out (chi_out[`IDX(0, y) +: 5])
      );
   end

`ifdef CHI_PIPELINE_EN
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle:  if (bus.start) state_d = StRun;
         StRun: begin
            // Counter wraps 63 -> 0 naturally on the last read.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_SLICE) state_d = StFlush;
         end
         StFlush: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Write side trails the read side by one cycle: slice read now is written next.
   assign rd_addr_d = (state_d == StRun) ? cnt_d : rd_addr_q;
   assign wr_addr_d = (state_q == StRun) ? cnt_q : wr_addr_q;
   assign bus.rd_en = (state_q == StRun);
   assign wr_en     = ((state_q == StRun) && (cnt_q != '0)) || (state_q == StFlush);
   assign bus.busy  = (state_q == StRun) || (state_q == StFlush);
`else
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle:  if (bus.start) state_d = StRead;
         StRead:  state_d = StWrite;
         StWrite: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == LAST_SLICE) ? StDone : StRead;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Address registers load only when their strobe is about to rise, so they
   // hold the last used slice index while idle.
   assign rd_addr_d = (state_d == StRead)  ? cnt_d : rd_addr_q;
   assign wr_addr_d = (state_d == StWrite) ? cnt_d : wr_addr_q;
   assign bus.rd_en = (state_q == StRead);
   assign wr_en     = (state_q == StWrite);
   assign bus.busy  = (state_q == StRead) || (state_q == StWrite);
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
      end
   end

   assign bus.done    = (state_q == StDone);
   assign bus.rd_addr = rd_addr_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_en   = wr_en;
   // Gated so the bus never carries X from an unread memory word.
   assign bus.wr_data = wr_en ? chi_out : '0;

endmodule

// File: tb/tb_chi_stage.sv
// Self-checking bench for chi_stage: table of whole-state vectors plus
// directed sequences for restart attempts and mid-run reset.
module tb_chi_stage;
   import chi_stage_pkg::*;

`ifdef CHI_PIPELINE_EN
   localparam int DONE_CYC    = 66;
   localparam int LAST_WR_CYC = 65;
`else
   localparam int DONE_CYC    = 129;
   localparam int LAST_WR_CYC = 128;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   chi_stage_if bus ();

   chi_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [SLICE_W-1:0] mem     [NUM_SLICES];
   logic [SLICE_W-1:0] exp_mem [NUM_SLICES];

   // Source memory: registered read, data valid one cycle after rd_en.
   always @(posedge clk) begin
      if (!rst) bus.rd_data <= '0;
      else if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
   end

   typedef struct {
      string              name;
      logic [SLICE_W-1:0] slice_in;
      logic [SLICE_W-1:0] slice_out;
   } vec_t;

   vec_t vecs [5];

   int checks = 0;
   int errors = 0;

   int n_wr, n_done, n_rd_after, first_rd, last_wr, done_cyc;
   int bad_data, bad_order, bad_busy, n_wr_after_rst, next_addr;
   int wr_hits [NUM_SLICES];
   logic [3:0]         snap_ctl;
   logic [CNT_W-1:0]   snap_rd_addr, snap_wr_addr;
   logic [SLICE_W-1:0] snap_wr_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [SLICE_W-1:0] ref_chi(input logic [SLICE_W-1:0] s);
      logic [SLICE_W-1:0] r;
      r = '0;
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            r[5*y+x] = s[5*y+x] ^ (~s[5*y+(x+1)%5] & s[5*y+(x+2)%5]);
      return r;
   endfunction

   // Pulses start, then observes a bounded window of cycles. Cycle c is the
   // interval after clock edge c; start is sampled at edge 0.
   task automatic run_pass(input int again1, input int again2, input int rst_cyc);
      n_wr = 0; n_done = 0; n_rd_after = 0; first_rd = -1; last_wr = -1;
      done_cyc = -1; bad_data = 0; bad_order = 0; bad_busy = 0;
      n_wr_after_rst = 0; next_addr = 0;
      snap_ctl = 'x; snap_rd_addr = 'x; snap_wr_addr = 'x; snap_wr_data = 'x;
      for (int i = 0; i < NUM_SLICES; i++) wr_hits[i] = 0;
      @(negedge clk);
      bus.start = 1'b1;
      for (int c = 1; c <= DONE_CYC + 4; c++) begin
         @(negedge clk);
         bus.start = (c == again1) || (c == again2);
         rst = (c != rst_cyc);
         if (rst_cyc > 0 && c == rst_cyc + 1) begin
            snap_ctl     = {bus.busy, bus.done, bus.rd_en, bus.wr_en};
            snap_rd_addr = bus.rd_addr;
            snap_wr_addr = bus.wr_addr;
            snap_wr_data = bus.wr_data;
         end
         if (bus.rd_en && first_rd < 0) first_rd = c;
         if (done_cyc >= 0 && bus.rd_en) n_rd_after++;
         if (bus.wr_en) begin
            n_wr++;
            last_wr = c;
            if (rst_cyc > 0 && c > rst_cyc) n_wr_after_rst++;
            if (bus.wr_addr != next_addr[CNT_W-1:0]) bad_order++;
            next_addr++;
            wr_hits[bus.wr_addr]++;
            if (bus.wr_data !== exp_mem[bus.wr_addr]) bad_data++;
         end
         if (bus.done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = c;
         end
         if ((rst_cyc < 0 || c <= rst_cyc) && done_cyc < 0 && bus.busy !== 1'b1) bad_busy++;
      end
      bus.start = 1'b0;
      rst = 1'b1;
   endtask

   task automatic check_pass(input string tag);
      int bad_hits;
      bad_hits = 0;
      for (int i = 0; i < NUM_SLICES; i++) if (wr_hits[i] != 1) bad_hits++;
      chk({tag, " write_count"}, n_wr, 64);
      chk({tag, " slices_once"}, bad_hits, 0);
      chk({tag, " order"}, bad_order, 0);
      chk({tag, " data"}, bad_data, 0);
      chk({tag, " first_rd_cyc"}, first_rd, 1);
      chk({tag, " last_wr_cyc"}, last_wr, LAST_WR_CYC);
      chk({tag, " done_cyc"}, done_cyc, DONE_CYC);
      chk({tag, " done_pulses"}, n_done, 1);
      chk({tag, " busy"}, bad_busy, 0);
      chk({tag, " no_restart"}, n_rd_after, 0);
   endtask

   initial begin
      vecs[0] = '{"zero",   25'h0000000, 25'h0000000};
      vecs[1] = '{"ones",   25'h1FFFFFF, 25'h1FFFFFF};
      vecs[2] = '{"x2y0",   25'h0000004, 25'h0000005};
      vecs[3] = '{"x0y0",   25'h0000001, 25'h0000009};
      vecs[4] = '{"x01y1",  25'h0000060, 25'h0000160};

      bus.start = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst busy", bus.busy, 0);
      chk("rst done", bus.done, 0);
      chk("rst rd_en", bus.rd_en, 0);
      chk("rst wr_en", bus.wr_en, 0);
      chk("rst rd_addr", bus.rd_addr, 0);
      chk("rst wr_addr", bus.wr_addr, 0);
      chk("rst wr_data", bus.wr_data, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle busy", bus.busy, 0);

      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < NUM_SLICES; i++) begin
            mem[i]     = vecs[v].slice_in;
            exp_mem[i] = vecs[v].slice_out;
         end
         run_pass(-1, -1, -1);
         check_pass(vecs[v].name);
      end

      // Single set bit in slice 5 only.
      for (int i = 0; i < NUM_SLICES; i++) begin
         mem[i] = '0;
         exp_mem[i] = '0;
      end
      mem[5] = 25'h0000004;
      exp_mem[5] = 25'h0000005;
      run_pass(-1, -1, -1);
      check_pass("single_bit");

      // Address order with start re-pulsed while busy and again during done.
      for (int i = 0; i < NUM_SLICES; i++) begin
         mem[i] = SLICE_W'(i);
         exp_mem[i] = ref_chi(SLICE_W'(i));
      end
      run_pass(10, DONE_CYC, -1);
      check_pass("addr_order");

      // Reset for one cycle at edge 40.
      run_pass(-1, -1, 40);
      chk("midrst ctl", {28'd0, snap_ctl}, 0);
      chk("midrst rd_addr", snap_rd_addr, 0);
      chk("midrst wr_addr", snap_wr_addr, 0);
      chk("midrst wr_data", snap_wr_data, 0);
      chk("midrst writes_after", n_wr_after_rst, 0);
      chk("midrst done_pulses", n_done, 0);
      run_pass(-1, -1, -1);
      check_pass("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/chi_stage.md
Name: chi_stage

Overview:
- Non-linear chi step of the round pipeline; sits directly upstream of the round-constant (iota) stage.
- Walks the 64-slice state memory slice by slice (25 bits per slice, 5x5 lanes) and applies chi to every 5-bit row.
- Writes results into the output slice memory that the iota stage consumes.
- Start/done handshake; an internal 6-bit slice counter sequences the memory reads and writes.

Parameters:
- SLICE_W, 25, bits per slice (5 rows x 5 columns).
- NUM_SLICES, 64, slices per state; counter width is log2(NUM_SLICES) = 6.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to process a full state; honoured only in IDLE
- busy  out  1  high from the cycle after start is accepted until done is asserted
- done  out  1  one-cycle pulse after the last slice is written
- rd_en  out  1  read strobe to the source slice memory
- rd_addr  out  6  slice index to read
- rd_data  in  25  slice data, valid exactly one cycle after rd_en
- wr_en  out  1  write strobe to the destination slice memory
- wr_addr  out  6  slice index being written
- wr_data  out  25  chi result for slice wr_addr

Behaviour:
- Bit mapping: slice bit index = 5*y + x, with x, y in 0..4.
- Chi: out[5y+x] = in[5y+x] ^ (~in[5y+(x+1)%5] & in[5y+(x+2)%5]). Purely combinational on rd_data.
- Reset (rst=0 at a clock edge) forces:
  - state = IDLE, counter = 0;
  - busy = 0, done = 0, rd_en = 0, wr_en = 0;
  - rd_addr = 0, wr_addr = 0, wr_data = 0.
- Reset mid-operation aborts immediately. No further writes are issued, and done is not pulsed.
- FSM, non-pipelined build: states IDLE, READ, WRITE, DONE.
  - IDLE: start=1 -> READ.
  - READ: rd_en=1, rd_addr=cnt -> WRITE.
  - WRITE: wr_en=1, wr_addr=cnt, wr_data=chi(rd_data).
    - If cnt==63: go to DONE; cnt wraps to 0.
    - Otherwise: cnt++ and go to READ.
  - DONE: done=1 for one cycle -> IDLE.
- Latency, non-pipelined: start sampled at edge 0.
  - First rd_en is in cycle 1.
  - Last wr_en is in cycle 128.
  - done is in cycle 129.
- start is ignored while busy or in DONE. Simultaneous start and done cause no restart.
- rd_addr and wr_addr hold their last value when the matching strobe is low.
- wr_data is a don't-care when wr_en=0, but must not be X after reset.
- Each slice is written exactly once per pass, in ascending order 0..63.

Optional Feature:
- Macro: CHI_PIPELINE_EN.
- Defined: states IDLE, RUN, FLUSH, DONE.
  - RUN issues one read per cycle for slices 0..63 (64 cycles).
  - The write of slice i occurs the cycle after its read, so reads and writes overlap.
  - FLUSH performs the final write (slice 63).
  - First rd_en in cycle 1, last wr_en in cycle 65, done in cycle 66.
  - A second, write-side counter register holds wr_addr.
- Undefined: the 2-cycle-per-slice FSM above.
- Port list, reset values and data results are identical in both builds.

Decomposition:
- Shared package/header holds:
  - SLICE_W, NUM_SLICES, CNT_W=6;
  - the state encodings;
  - a lane-index macro IDX(x,y)=5*y+x, shared with the theta/rho/pi/iota stages.
- One sub-module, chi_row: combinational, 5-bit in -> 5-bit out. Instantiated 5 times for rows y=0..4.
- The slice counter reuses the existing parameterised counter with width 6 and rst_value 0.

Test Plan:
- Zero state: memory all 25'h0000000, pulse start -> 64 writes, all wr_data=25'h0; done in cycle 129 (pipelined build: 66).
- Ones state: slice = 25'h1FFFFFF -> wr_data = 25'h1FFFFFF for every slice.
- Single bit: slice 5 = 25'h0000004 (x=2, y=0), others zero -> slice 5 written as 25'h0000005; all others 25'h0.
- Address order: memory[i] = i -> wr_addr sequence 0..63 ascending, exactly one write per slice; each wr_data matches a reference chi model; busy stays high throughout.
- Start while busy: pulse start again at cycle 10 -> ignored; exactly 64 writes and one done pulse.
- Reset mid-run: drive rst=0 at cycle 40 for one cycle -> next cycle busy=0, wr_en=0, rd_en=0, no done pulse. A new start then completes a full, correct pass.
